// File: rtl/keypad_scan_p_if.sv
// Keypad scanner bus: row sense lines in, column drive and accepted-key report out.
interface keypad_scan_p_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Scanner side
  modport slave (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  // Keypad / host side
  modport master (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_p.sv
// 4x4 matrix keypad scanner with ghost rejection and press/release debouncing.
module keypad_scan_p #(
  parameter int unsigned SCAN_PERIOD    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic           clk,
  input  logic           reset,
  keypad_scan_p_if.slave kp
);

  localparam int unsigned CNT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [3:0]       COL0_SEL  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_e;

  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       col_q;
  logic [3:0][3:0]  snap_q;

  state_e           state_q;
  logic [3:0]       latch_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;

  logic             tick;
  logic             full_scan;
  logic [1:0]       col_idx_d;
  logic [15:0]      scan_c;
  logic [4:0]       low_cnt;
  logic [3:0]       cand_code;
  logic             cand_valid;
  logic [DEB_W-1:0] deb_inc;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign full_scan = tick && (col_idx_q == 2'd3);
  assign col_idx_d = col_idx_q + 2'd1;
  assign deb_inc   = deb_cnt_q + DEB_ONE;

  // Row synchronizer, scan timebase, column drive and per-column snapshots
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      tick_cnt_q <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      snap_q     <= '1;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      if (tick) begin
        tick_cnt_q        <= '0;
        snap_q[col_idx_q] <= row_sync_q;
        col_idx_q         <= col_idx_d;
        col_q             <= ~(COL0_SEL << col_idx_d);
      end else begin
        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
      end
    end
  end

  // Full-scan image: column 3 is taken live since it is sampled on this same tick
  always_comb begin
    scan_c    = {row_sync_q, snap_q[2], snap_q[1], snap_q[0]};
    low_cnt   = 5'd0;
    cand_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (!scan_c[i]) begin
        low_cnt   = low_cnt + 5'd1;
        cand_code = 4'(i);
      end
    end
  end

  // Only a single pressed key forms a candidate; two or more is ghosting
  assign cand_valid = (low_cnt == 5'd1);

  // Debounce FSM, advanced only on full-scan ticks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      latch_q     <= 4'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (full_scan) begin
        case (state_q)
          IDLE: begin
            if (cand_valid) begin
              latch_q   <= cand_code;
              deb_cnt_q <= DEB_ONE;
              if (DEB_LAST == DEB_ONE) begin
                state_q     <= PRESSED;
                key_code_q  <= cand_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
              end else begin
                state_q <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (!cand_valid) begin
              state_q <= IDLE;
            end else if (cand_code != latch_q) begin
              latch_q   <= cand_code;
              deb_cnt_q <= DEB_ONE;
            end else if (deb_inc == DEB_LAST) begin
              deb_cnt_q   <= deb_inc;
              state_q     <= PRESSED;
              key_code_q  <= latch_q;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end else begin
              deb_cnt_q <= deb_inc;
            end
          end
          PRESSED: begin
            if (!cand_valid || (cand_code != key_code_q)) begin
              deb_cnt_q <= DEB_ONE;
              if (DEB_LAST == DEB_ONE) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
              end else begin
                state_q <= DEB_RELEASE;
              end
            end
          end
          DEB_RELEASE: begin
            if (cand_valid && (cand_code == key_code_q)) begin
              state_q <= PRESSED;
            end else if (deb_inc == DEB_LAST) begin
              deb_cnt_q  <= deb_inc;
              state_q    <= IDLE;
              key_held_q <= 1'b0;
            end else begin
              deb_cnt_q <= deb_inc;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_p.sv
// Scoreboard bench for keypad_scan_p with SCAN_PERIOD=4, DEBOUNCE_SCANS=2.
module tb_keypad_scan_p;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys  = 16'h0000;
  logic [3:0]  row_m;
  int          n;
  int          checks = 0;
  int          errors = 0;
  int          n0;

  typedef struct {
    logic [3:0] code;
    int         exp_n;
  } exp_t;
  exp_t sb[$];

  keypad_scan_p_if kp();

  keypad_scan_p #(
    .SCAN_PERIOD   (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_m = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !kp.col[c]) row_m[r] = 1'b0;
  end
  assign kp.row = row_m;

  // Clock edges since reset release; 16 edges per full scan
  always @(posedge clk or negedge reset) begin
    if (!reset) n <= 0;
    else        n <= n + 1;
  end

  function automatic logic [3:0] exp_col(input int cyc);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((cyc / 4) % 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at n=%0d", name, act, exp, n);
    end
  endtask

  // Wait for the first negedge right after a full-scan tick
  task automatic align();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((n % 16 != 0) && (k < 40));
    if (n % 16 != 0) begin
      checks++;
      errors++;
      $display("FAIL align_timeout: n=%0d expected multiple of 16", n);
    end
  endtask

  // Column drive follows the scan timebase every cycle
  initial begin
    forever begin
      @(negedge clk);
      check("col", 32'(kp.col), 32'(exp_col(n)));
    end
  end

  // Monitor: every key_valid pulse must match the next expected press
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_valid_unexpected: got code %0h expected no pulse at n=%0d", kp.key_code, n);
        end else begin
          e = sb.pop_front();
          check("valid_code", 32'(kp.key_code), 32'(e.code));
          check("valid_held", 32'(kp.key_held), 32'd1);
          if (e.exp_n >= 0) check("valid_time", 32'(n), 32'(e.exp_n));
        end
      end
    end
  end

  initial begin
    // Reset values
    repeat (5) @(negedge clk);
    check("rst_col",   32'(kp.col),       32'hE);
    check("rst_code",  32'(kp.key_code),  32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_held",  32'(kp.key_held),  32'h0);
    reset = 1'b1;

    // Idle scanning
    repeat (200) @(negedge clk);
    check("idle_held", 32'(kp.key_held), 32'h0);

    // Press key 9 aligned to a scan boundary: accepted at the end of the second scan
    align();
    keys = 16'h0200;
    sb.push_back('{4'h9, n + 32});
    repeat (48) @(negedge clk);
    check("press_held", 32'(kp.key_held), 32'h1);
    check("press_code", 32'(kp.key_code), 32'h9);

    // One missing scan does not drop key_held or re-pulse
    align();
    keys = 16'h0000;
    repeat (16) @(negedge clk);
    keys = 16'h0200;
    check("glitch_held_a", 32'(kp.key_held), 32'h1);
    repeat (24) @(negedge clk);
    check("glitch_held_b", 32'(kp.key_held), 32'h1);

    // Release: key_held falls after two NONE scans, key_code kept
    align();
    keys = 16'h0000;
    repeat (31) @(negedge clk);
    check("rel_held_pre", 32'(kp.key_held), 32'h1);
    @(negedge clk);
    check("rel_held_post", 32'(kp.key_held), 32'h0);
    check("rel_code_kept", 32'(kp.key_code), 32'h9);

    // Bounce on key 9 for 60 clks, then held: single pulse after two clean scans
    align();
    n0 = n;
    repeat (3) @(negedge clk);
    sb.push_back('{4'h9, n0 + 96});
    for (int j = 0; j < 60; j++) begin
      keys = (((j / 6) % 2) == 0) ? 16'h0200 : 16'h0000;
      @(negedge clk);
    end
    keys = 16'h0200;
    repeat (40) @(negedge clk);
    check("bounce_held", 32'(kp.key_held), 32'h1);
    keys = 16'h0000;
    repeat (64) @(negedge clk);
    check("bounce_rel_held", 32'(kp.key_held), 32'h0);

    // Ghost: keys 0 and 5 together are rejected; releasing 5 accepts 0
    align();
    keys = 16'h0021;
    repeat (48) @(negedge clk);
    check("ghost_held", 32'(kp.key_held), 32'h0);
    check("ghost_code", 32'(kp.key_code), 32'h9);
    align();
    keys = 16'h0001;
    sb.push_back('{4'h0, n + 32});
    repeat (40) @(negedge clk);
    check("ghost_rel_held", 32'(kp.key_held), 32'h1);
    check("ghost_rel_code", 32'(kp.key_code), 32'h0);
    keys = 16'h0000;
    repeat (64) @(negedge clk);
    check("ghost_idle_held", 32'(kp.key_held), 32'h0);

    // Reset after the first stable scan of key 3 aborts the press
    align();
    keys = 16'h0008;
    repeat (18) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_col",   32'(kp.col),       32'hE);
    check("midrst_valid", 32'(kp.key_valid), 32'h0);
    check("midrst_held",  32'(kp.key_held),  32'h0);
    check("midrst_code",  32'(kp.key_code),  32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.push_back('{4'h3, 32});
    repeat (48) @(negedge clk);
    check("post_rst_held", 32'(kp.key_held), 32'h1);
    check("post_rst_code", 32'(kp.key_code), 32'h3);

    repeat (5) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL key_valid_missing: got no pulse expected code %0h at n=%0d", e.code, e.exp_n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
